// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, width helper and status struct for fifo_sync_param
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 64;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_dpram.sv
// rtl/fifo_dpram.sv - simple dual-port RAM, one write and one read port
// FIFO_FWFT_EN selects asynchronous read; otherwise the read port is registered and resettable.
module fifo_dpram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
`ifndef FIFO_FWFT_EN
  input  logic             rst,
  input  logic             re,
`endif
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  // The output register holds its value between pops, so only it is reset.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with count, level flags and sticky errors
// FIFO_FWFT_EN selects first-word fall-through reads; default is a 1-cycle registered read.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL   = FIFO_DEPTH - 4,
  parameter int AE_LEVEL   = 4,
  localparam int AW        = addr_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [AW:0]           count,
  output logic [AW-1:0]         wrptr,
  output logic [AW-1:0]         rdptr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic wr_acc;
  logic rd_acc;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // The count alone separates full from empty; wrptr == rdptr occurs in both.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrptr     <= '0;
      rdptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wrptr <= wrptr + AW'(1);
      if (rd_acc) rdptr <= rdptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  assign rd_valid = ~empty;

  fifo_dpram #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wrptr),
    .wdata (data_in),
    .raddr (rdptr),
    .rdata (data_out)
  );
`else
  always_ff @(posedge clk) begin
    if (rst) rd_valid <= 1'b0;
    else     rd_valid <= rd_acc;
  end

  fifo_dpram #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .re    (rd_acc),
    .we    (wr_acc),
    .waddr (wrptr),
    .wdata (data_in),
    .raddr (rdptr),
    .rdata (data_out)
  );
`endif

endmodule
